flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/wisc_pkg.sv | 24 ++
 rtl/flag_unit_if.sv | 40 ++++
 rtl/flag_unit_cond_eval.sv | 30 +++
 rtl/flag_unit.sv | 116 +++++++++++
 tb/tb_flag_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared encodings for the flag unit.
//   CCC_*   : 3-bit branch condition codes decoded by cond_eval.
//   state_t : 2-bit halt-sequencing FSM state (RUN=00, DRAIN=01, HALTED=10).
//   CNT_W   : width of the branch statistics counters.
package wisc_pkg;

  localparam logic [2:0] CCC_NEQ    = 3'b000;
  localparam logic [2:0] CCC_EQ     = 3'b001;
  localparam logic [2:0] CCC_GT     = 3'b010;
  localparam logic [2:0] CCC_LT     = 3'b011;
  localparam logic [2:0] CCC_GTE    = 3'b100;
  localparam logic [2:0] CCC_LTE    = 3'b101;
  localparam logic [2:0] CCC_OVFL   = 3'b110;
  localparam logic [2:0] CCC_UNCOND = 3'b111;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

endpackage

// File: rtl/flag_unit_if.sv
// Pipeline-side bus of the flag unit.
//   master : pipeline control (drives EX/ID/WB info, samples decision/flags/stats)
//   slave  : flag_unit (samples pipeline info, drives taken/flags/halted/counters)
interface flag_unit_if;
  import wisc_pkg::*;

  logic             ex_valid;
  logic             ex_set_n;
  logic             ex_set_z;
  logic             ex_set_v;
  logic             ex_n;
  logic             ex_z;
  logic             ex_v;
  logic             stall;
  logic             flush;
  logic             id_branch;
  logic [2:0]       id_ccc;
  logic             id_halt;
  logic             wb_halt;
  logic             taken;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;
  logic             halted;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] tk_cnt;

  modport master (
    output ex_valid, ex_set_n, ex_set_z, ex_set_v, ex_n, ex_z, ex_v,
    output stall, flush, id_branch, id_ccc, id_halt, wb_halt,
    input  taken, flag_n, flag_z, flag_v, halted, br_cnt, tk_cnt
  );

  modport slave (
    input  ex_valid, ex_set_n, ex_set_z, ex_set_v, ex_n, ex_z, ex_v,
    input  stall, flush, id_branch, id_ccc, id_halt, wb_halt,
    output taken, flag_n, flag_z, flag_v, halted, br_cnt, tk_cnt
  );

endinterface

// File: rtl/flag_unit_cond_eval.sv
// Combinational branch condition evaluator.
//   ccc     : condition code (wisc_pkg CCC_*)
//   n, z, v : flag values to test
//   out     : 1 when the condition holds
module cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  output logic       out
);

  always_comb begin
    out = 1'b0;
    unique case (ccc)
      CCC_NEQ:    out = ~z;
      CCC_EQ:     out = z;
      CCC_GT:     out = ~z & ~n;
      CCC_LT:     out = n;
      CCC_GTE:    out = ~n | z;
      CCC_LTE:    out = n | z;
      CCC_OVFL:   out = v;
      CCC_UNCOND: out = 1'b1;
      default:    out = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural N/Z/V flags, zero-latency branch decision, halt sequencing
// and saturating branch statistics.
//   clk   : pipeline clock
//   rst_n : synchronous active-low reset
//   bus   : flag_unit_if.slave (EX flag results, stall/flush, ID branch/halt,
//           WB halt in; taken, flags, halted, br_cnt, tk_cnt out)
module flag_unit
  import wisc_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  flag_unit_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] tk_cnt;
  logic             commit;
  logic             res_n;
  logic             res_z;
  logic             res_v;
  logic             cond_out;
  logic             taken;
  logic             halted;
  logic             cnt_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  assign commit = bus.ex_valid & ~bus.stall & ~bus.flush & (state != ST_HALTED);

  // A branch in ID sees the flags its EX predecessor is producing this cycle,
  // even while EX is stalled, so the decision never has to wait.
  assign res_n = (bus.ex_valid & ~bus.flush & bus.ex_set_n) ? bus.ex_n : flag_n;
  assign res_z = (bus.ex_valid & ~bus.flush & bus.ex_set_z) ? bus.ex_z : flag_z;
  assign res_v = (bus.ex_valid & ~bus.flush & bus.ex_set_v) ? bus.ex_v : flag_v;

  cond_eval u_cond (
    .ccc (bus.id_ccc),
    .n   (res_n),
    .z   (res_z),
    .v   (res_v),
    .out (cond_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next-state logic. A HLT reaching WB is architecturally committed, so it
  // wins over a same-cycle flush (which only squashes younger EX/ID work).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN: begin
        if (bus.wb_halt)                                  state_nxt = ST_HALTED;
        else if (bus.id_halt & ~bus.stall & ~bus.flush)   state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.wb_halt)    state_nxt = ST_HALTED;
        else if (bus.flush) state_nxt = ST_RUN;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Output logic: branches are only resolved and counted while running.
  always_comb begin
    taken  = 1'b0;
    halted = 1'b0;
    cnt_en = 1'b0;
    unique case (state)
      ST_RUN: begin
        taken  = bus.id_branch & ~bus.flush & cond_out;
        cnt_en = bus.id_branch & ~bus.stall & ~bus.flush;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      br_cnt <= '0;
      tk_cnt <= '0;
    end else begin
      if (commit & bus.ex_set_n) flag_n <= bus.ex_n;
      if (commit & bus.ex_set_z) flag_z <= bus.ex_z;
      if (commit & bus.ex_set_v) flag_v <= bus.ex_v;
      if (cnt_en) begin
        br_cnt <= sat_inc(br_cnt);
        if (taken) tk_cnt <= sat_inc(tk_cnt);
      end
    end
  end

  assign bus.taken  = taken;
  assign bus.halted = halted;
  assign bus.flag_n = flag_n;
  assign bus.flag_z = flag_z;
  assign bus.flag_v = flag_v;
  assign bus.br_cnt = br_cnt;
  assign bus.tk_cnt = tk_cnt;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: the driver pushes expected outputs from a
// behavioural model; a negedge monitor pops and compares.
module tb_flag_unit;
  import wisc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flag_unit_if bus ();

  flag_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          known;
    bit          taken;
    bit [2:0]    flags;
    bit          halted;
    bit [15:0]   br;
    bit [15:0]   tk;
  } exp_t;

  typedef enum {M_RUN, M_DRAIN, M_HALT} mode_e;

  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  bit    m_known = 0;
  bit    m_n, m_z, m_v;
  mode_e m_mode;
  int    m_br, m_tk;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit cond(bit [2:0] c, bit n, bit z, bit v);
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return !n || z;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  // Push this cycle's expectations, advance the model across the edge, then
  // return 1 time unit after the edge with inputs still held.
  task automatic tick();
    exp_t e;
    bit rn, rz, rv, tk, live;
    live = bus.ex_valid && !bus.flush;
    rn = (live && bus.ex_set_n) ? bus.ex_n : m_n;
    rz = (live && bus.ex_set_z) ? bus.ex_z : m_z;
    rv = (live && bus.ex_set_v) ? bus.ex_v : m_v;
    tk = bus.id_branch && !bus.flush && (m_mode == M_RUN) && cond(bus.id_ccc, rn, rz, rv);
    e.known  = m_known;
    e.taken  = tk;
    e.flags  = {m_n, m_z, m_v};
    e.halted = (m_mode == M_HALT);
    e.br     = 16'(m_br);
    e.tk     = 16'(m_tk);
    sb.push_back(e);
    if (!rst_n) begin
      m_known = 1; m_n = 0; m_z = 0; m_v = 0;
      m_mode = M_RUN; m_br = 0; m_tk = 0;
    end else if (m_known) begin
      if (bus.ex_valid && !bus.stall && !bus.flush && m_mode != M_HALT) begin
        if (bus.ex_set_n) m_n = bus.ex_n;
        if (bus.ex_set_z) m_z = bus.ex_z;
        if (bus.ex_set_v) m_v = bus.ex_v;
      end
      if (bus.id_branch && !bus.stall && !bus.flush && m_mode == M_RUN) begin
        if (m_br < 65535) m_br++;
        if (tk && m_tk < 65535) m_tk++;
      end
      case (m_mode)
        M_RUN:   if (bus.wb_halt) m_mode = M_HALT;
                 else if (bus.id_halt && !bus.stall && !bus.flush) m_mode = M_DRAIN;
        M_DRAIN: if (bus.wb_halt) m_mode = M_HALT;
                 else if (bus.flush) m_mode = M_RUN;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.known) begin
        chk("taken",  16'(bus.taken), 16'(e.taken));
        chk("flags",  16'({bus.flag_n, bus.flag_z, bus.flag_v}), 16'(e.flags));
        chk("halted", 16'(bus.halted), 16'(e.halted));
        chk("br_cnt", bus.br_cnt, e.br);
        chk("tk_cnt", bus.tk_cnt, e.tk);
      end
    end
  end

  task automatic idle();
    rst_n = 1;
    bus.ex_valid = 0; bus.ex_set_n = 0; bus.ex_set_z = 0; bus.ex_set_v = 0;
    bus.ex_n = 0; bus.ex_z = 0; bus.ex_v = 0;
    bus.stall = 0; bus.flush = 0;
    bus.id_branch = 0; bus.id_ccc = 3'd0; bus.id_halt = 0; bus.wb_halt = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic alu_all(bit n, bit z, bit v);
    bus.ex_valid = 1; bus.ex_set_n = 1; bus.ex_set_z = 1; bus.ex_set_v = 1;
    bus.ex_n = n; bus.ex_z = z; bus.ex_v = v;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_flags", 16'({bus.flag_n, bus.flag_z, bus.flag_v}), 16'h0);
    chk("rst_halted", 16'(bus.halted), 16'h0);
    chk("rst_br", bus.br_cnt, 16'h0);

    // SUB sets Z only
    alu_all(0, 1, 0); tick(); idle();
    chk("sub_z", 16'(bus.flag_z), 16'h1);
    chk("sub_n", 16'(bus.flag_n), 16'h0);
    chk("sub_v", 16'(bus.flag_v), 16'h0);
    tick();

    // Forwarded Z to an EQ branch
    do_reset();
    bus.ex_valid = 1; bus.ex_set_z = 1; bus.ex_z = 1;
    bus.id_branch = 1; bus.id_ccc = CCC_EQ;
    #1 chk("fwd_taken", 16'(bus.taken), 16'h1);
    tick(); idle(); tick();

    // XOR does not write N, LT must not fire
    do_reset();
    bus.ex_valid = 1; bus.ex_n = 1;
    bus.id_branch = 1; bus.id_ccc = CCC_LT;
    #1 chk("xor_taken", 16'(bus.taken), 16'h0);
    tick(); idle();
    chk("xor_n", 16'(bus.flag_n), 16'h0);
    tick();

    // Stalled EX commits once on release; ID branch counted once
    do_reset();
    alu_all(1, 0, 1); bus.id_branch = 1; bus.id_ccc = CCC_UNCOND; bus.stall = 1;
    repeat (3) tick();
    chk("stall_n", 16'(bus.flag_n), 16'h0);
    chk("stall_br", bus.br_cnt, 16'h0);
    bus.stall = 0; tick(); idle();
    chk("rel_n", 16'(bus.flag_n), 16'h1);
    chk("rel_br", bus.br_cnt, 16'h1);
    tick();

    // Halt sweep
    do_reset();
    bus.id_halt = 1; tick(); idle();
    bus.id_branch = 1; bus.id_ccc = CCC_UNCOND;
    #1 chk("drain_taken", 16'(bus.taken), 16'h0);
    tick(); idle();
    bus.flush = 1; tick(); idle();
    bus.id_branch = 1; bus.id_ccc = CCC_UNCOND;
    #1 chk("run_taken", 16'(bus.taken), 16'h1);
    tick(); idle();
    bus.id_halt = 1; tick(); idle();
    bus.wb_halt = 1; tick(); idle();
    chk("halted", 16'(bus.halted), 16'h1);
    alu_all(1, 1, 1); repeat (2) tick(); idle();
    chk("halt_flags", 16'({bus.flag_n, bus.flag_z, bus.flag_v}), 16'h0);
    chk("halt_br", bus.br_cnt, 16'h1);
    rst_n = 0; tick(); rst_n = 1;
    chk("unhalt", 16'(bus.halted), 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 59) != 0);
      bus.ex_valid  = 1'($urandom);
      bus.ex_set_n  = 1'($urandom);
      bus.ex_set_z  = 1'($urandom);
      bus.ex_set_v  = 1'($urandom);
      bus.ex_n      = 1'($urandom);
      bus.ex_z      = 1'($urandom);
      bus.ex_v      = 1'($urandom);
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.flush     = ($urandom_range(0, 5) == 0);
      bus.id_branch = 1'($urandom);
      bus.id_ccc    = 3'($urandom);
      bus.id_halt   = ($urandom_range(0, 15) == 0);
      bus.wb_halt   = ($urandom_range(0, 24) == 0);
      if (bus.wb_halt) bus.flush = 0;
      tick();
    end

    // Counter saturation
    do_reset();
    bus.id_branch = 1; bus.id_ccc = CCC_UNCOND;
    repeat (65534) tick();
    chk("br_fffe", bus.br_cnt, 16'hFFFE);
    chk("tk_fffe", bus.tk_cnt, 16'hFFFE);
    repeat (3) tick();
    idle();
    chk("br_sat", bus.br_cnt, 16'hFFFF);
    chk("tk_sat", bus.tk_cnt, 16'hFFFF);
    tick();

    repeat (4) @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
